// File: rtl/fifo_sync_flex.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides, arbitrary depth,
// occupancy count, almost-full/almost-empty flags and a synchronous flush.
module fifo_sync_flex #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEPTH           = 5,
  parameter int unsigned ALMOST_FULL_TH  = 4,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         flush_i,
  input  logic [DATA_WIDTH-1:0]        data_in_i,
  input  logic                         data_in_valid_i,
  output logic                         data_in_ready_o,
  output logic [DATA_WIDTH-1:0]        data_out_o,
  output logic                         data_out_valid_o,
  input  logic                         data_out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o
);

  localparam int unsigned PtrW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfTh    = CntW'(ALMOST_FULL_TH);
  localparam logic [CntW-1:0] AeTh    = CntW'(ALMOST_EMPTY_TH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_flex: DEPTH must be at least 2");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $error("fifo_sync_flex: ALMOST_FULL_TH must be in 1..DEPTH");
  end
  if (ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_flex: ALMOST_EMPTY_TH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push, pop;

  always_comb begin
    data_in_ready_o  = !srst_i && !flush_i && (count_q < CntFull);
    data_out_valid_o = !srst_i && !flush_i && (count_q != '0);
    push             = data_in_valid_i && data_in_ready_o;
    pop              = data_out_valid_o && data_out_ready_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; push is already gated by srst_i/flush_i.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in_i;
    end
  end

  always_comb begin
    data_out_o     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    count_o        = count_q;
    almost_full_o  = (count_q >= AfTh);
    almost_empty_o = (count_q <= AeTh);
  end

endmodule

// File: doc/fifo_sync_flex.md
# fifo_sync_flex

Parametrised synchronous FIFO with valid/ready handshake on both sides, arbitrary (non-power-of-two) depth, occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. It is the general-purpose buffering stage between streaming producers and consumers. It is first-word-fall-through: the head entry is presented on the output without a read request.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥1)
- DEPTH, 5, number of storage entries (≥2, any integer)
- ALMOST_FULL_TH, 4, almost_full_o asserts when count ≥ this (1..DEPTH)
- ALMOST_EMPTY_TH, 1, almost_empty_o asserts when count ≤ this (0..DEPTH-1)

- clk_i  in  1  clock, all logic on rising edge
- srst_i  in  1  reset; one clock; reset is synchronous and active-high
- flush_i  in  1  synchronous clear of contents, active-high
- data_in_i  in  DATA_WIDTH  write payload
- data_in_valid_i  in  1  producer has payload
- data_in_ready_o  out  1  FIFO accepts payload this cycle
- data_out_o  out  DATA_WIDTH  head-of-queue payload
- data_out_valid_o  out  1  head entry valid
- data_out_ready_i  in  1  consumer takes head this cycle
- count_o  out  $clog2(DEPTH+1)  current occupancy
- almost_full_o  out  1  count_o ≥ ALMOST_FULL_TH
- almost_empty_o  out  1  count_o ≤ ALMOST_EMPTY_TH

## Operation
- State: storage array mem[DEPTH], wr_ptr and rd_ptr of width $clog2(DEPTH), count register. No explicit FSM; state is fully captured by the pointers and count.
- Push = data_in_valid_i && data_in_ready_o. On push, mem[wr_ptr] ← data_in_i and wr_ptr advances.
- Pop = data_out_valid_o && data_out_ready_i. On pop, rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. No power-of-two masking.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither. The count never leaves 0..DEPTH.
- data_in_ready_o = !srst_i && !flush_i && (count < DEPTH). It does not depend on data_out_ready_i, so a full FIFO rejects a push even in a cycle with a pop.
- data_out_valid_o = !srst_i && !flush_i && (count != 0).
- data_out_o = mem[rd_ptr] when count != 0, otherwise all zeros. Storage itself is not reset.
- Flush: next edge sets wr_ptr, rd_ptr and count to 0. Ready and valid are forced low during the flush cycle, so no transfer can occur in it.
- Priority: srst_i > flush_i > push/pop.
- almost_full_o and almost_empty_o decode combinationally from the count register. Both may be high at once for small DEPTH.
- Elaboration check fires if ALMOST_FULL_TH or ALMOST_EMPTY_TH is out of range, or if DEPTH < 2.

## Timing
- Reset values, after the edge with srst_i high: count_o = 0, data_out_valid_o = 0, data_out_o = 0, almost_full_o = (ALMOST_FULL_TH == 0 ? 1 : 0) (effectively 0), almost_empty_o = 1.
- data_in_ready_o is 0 while srst_i is high and 1 on the first cycle after srst_i drops.
- Write-to-read latency is 1 cycle. A payload pushed at edge k appears on data_out_o with valid in the cycle after edge k.
- Pop-to-next-head latency is 0 extra cycles. After the pop edge, the next entry is presented immediately.
- A full FIFO with a pop at edge k asserts data_in_ready_o in the cycle after edge k.
- Throughput is one push and one pop per cycle at any occupancy 1..DEPTH-1.
- Reset or flush mid-burst discards all contents at that edge. In-flight handshakes in that cycle do not complete.
- All outputs are glitch-free functions of registers, except that ready and valid are also gated by srst_i and flush_i.

## Test plan
- Reset, then push 0x11,0x22,0x33,0x44,0x55 with data_out_ready_i = 0:
  - count_o goes 1..5.
  - almost_full_o rises with count 4.
  - data_in_ready_o is 0 with count 5.
  - A sixth push of 0x66 is held and not stored.
- From full, hold data_out_ready_i = 1:
  - Outputs are 0x11..0x55 on consecutive cycles.
  - almost_empty_o rises at count 1.
  - valid drops and data_out_o = 0 at count 0.
- Continuous push/pop with valid and ready both always 1, 13 beats 0x01..0x0D:
  - Output sequence is identical and in order across pointer wrap at DEPTH = 5.
  - count_o is steady at 1 after the first beat.
- Full FIFO, push and pop asserted in the same cycle:
  - Pop completes, push is blocked, count_o = 4.
  - Next cycle, ready = 1 and the held payload is accepted, count_o = 5.
- Three entries stored, flush_i pulsed for one cycle with valid_i = 1 and ready_i = 1:
  - Ready and valid are 0 in that cycle and no transfer occurs.
  - Next cycle count_o = 0, almost_empty_o = 1.
  - A following push of 0xA5 is output as 0xA5.
- srst_i asserted mid-burst at count 3 while pushing:
  - All outputs reach their reset values.
  - After release, the first pushed value is the first popped value.
